// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 encodings and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ISSUE,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_req_check.sv
// Request classifier: funct3 legality for the selected operation and address alignment.
module lsu_req_check
  import lsu_pkg::*;
(
  input  logic [2:0] i_func3,
  input  logic [1:0] i_addr,
  input  logic       i_load,
  input  logic       i_store,
  output logic       o_legal,
  output logic       o_aligned
);

  logic w_ld_ok;
  logic w_st_ok;

  // Which funct3 encodings each operation accepts.
  always_comb begin
    w_ld_ok = 1'b0;
    w_st_ok = 1'b0;
    case (i_func3)
      F3_B, F3_H, F3_W: begin
        w_ld_ok = 1'b1;
        w_st_ok = 1'b1;
      end
      F3_BU, F3_HU: w_ld_ok = 1'b1;
      default: ;
    endcase
  end

  // Load+store together is never legal, so exactly one operation must be selected.
  assign o_legal = (i_load & ~i_store & w_ld_ok) | (i_store & ~i_load & w_st_ok);

  // Access size comes from funct3[1:0]; bytes are always aligned.
  always_comb begin
    o_aligned = 1'b0;
    case (i_func3[1:0])
      2'b00:   o_aligned = 1'b1;
      2'b01:   o_aligned = ~i_addr[0];
      2'b10:   o_aligned = (i_addr == 2'b00);
      default: o_aligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: validates a request, drives the memory strobe
// protocol with registered, stable signals, waits out busywait (with optional
// timeout) and returns load data to writeback.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        access_err,
  output logic        timeout_err,
  output logic        mem_Read,
  output logic        mem_Write,
  output logic [31:0] mem_Address,
  output logic [31:0] mem_Write_data,
  output logic [2:0]  mem_Func3,
  input  logic [31:0] mem_Read_data,
  input  logic        mem_busywait
);

  lsu_state_e       r_state;
  lsu_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic w_legal;
  logic w_aligned;
  logic w_accept;
  logic w_bad;
  logic w_mis;
  logic w_tmo;

  lsu_req_check u_chk (
    .i_func3   (req_func3),
    .i_addr    (req_addr[1:0]),
    .i_load    (req_load),
    .i_store   (req_store),
    .o_legal   (w_legal),
    .o_aligned (w_aligned)
  );

  // Illegal wins over misaligned; a request with neither op set is simply ignored.
  assign w_accept = req_valid & w_legal & w_aligned;
  assign w_bad    = req_valid & (req_load | req_store) & ~w_legal;
  assign w_mis    = req_valid & w_legal & ~w_aligned;
  assign w_tmo    = (TIMEOUT_CYCLES != 0) && (r_state == LSU_WAIT) && mem_busywait &&
                    (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= LSU_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; busywait is ignored in ISSUE since it rises off the strobe itself.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LSU_IDLE:  if (w_accept) w_state_nxt = LSU_ISSUE;
      LSU_ISSUE: w_state_nxt = LSU_WAIT;
      LSU_WAIT:  if (!mem_busywait || w_tmo) w_state_nxt = LSU_DONE;
      LSU_DONE:  w_state_nxt = LSU_IDLE;
      default:   w_state_nxt = LSU_IDLE;
    endcase
  end

  // Stall covers the request cycle through the last WAIT cycle; DONE lets the pipe advance.
  always_comb begin
    stall = (r_state == LSU_ISSUE) | (r_state == LSU_WAIT) | ((r_state == LSU_IDLE) & w_accept);
  end

  // Busy-cycle counter for the WAIT timeout, cleared on the way into WAIT.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                                  r_cnt <= '0;
    else if (r_state == LSU_ISSUE)              r_cnt <= '0;
    else if (r_state == LSU_WAIT && mem_busywait) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Memory-side registers, load result and one-cycle status pulses.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mem_Read       <= 1'b0;
      mem_Write      <= 1'b0;
      mem_Address    <= '0;
      mem_Write_data <= '0;
      mem_Func3      <= '0;
      load_data      <= '0;
      load_valid     <= 1'b0;
      misaligned     <= 1'b0;
      access_err     <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      load_valid  <= 1'b0;
      misaligned  <= 1'b0;
      access_err  <= 1'b0;
      timeout_err <= 1'b0;
      case (r_state)
        LSU_IDLE: begin
          if (w_accept) begin
            mem_Address    <= req_addr;
            mem_Func3      <= req_func3;
            mem_Write_data <= req_wdata;
            mem_Read       <= req_load;
            mem_Write      <= req_store;
          end else begin
            misaligned <= w_mis;
            access_err <= w_bad;
          end
        end
        LSU_WAIT: begin
          if (!mem_busywait) begin
            mem_Read  <= 1'b0;
            mem_Write <= 1'b0;
            if (mem_Read) begin
              load_data  <= mem_Read_data;
              load_valid <= 1'b1;
            end
          end else if (w_tmo) begin
            mem_Read    <= 1'b0;
            mem_Write   <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural byte-addressed memory with programmable
// busy latency, directed scenarios followed by randomized requests, all checked
// against a request-level reference model.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        Clock, Reset;
  logic        req_valid, req_load, req_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, load_valid, misaligned, access_err, timeout_err;
  logic [31:0] load_data;
  logic        mem_Read, mem_Write;
  logic [31:0] mem_Address, mem_Write_data, mem_Read_data;
  logic [2:0]  mem_Func3;
  logic        mem_busywait;

  int n_cmp, n_err;

  logic [7:0]  mem      [64];
  logic [7:0]  init_mem [64];
  logic [7:0]  ref_mem  [64];
  logic        m_load;
  int          m_lat;
  int          m_cnt;
  logic [31:0] m_word, m_sh;
  logic [31:0] exp_ld;

  load_store_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset),
    .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_valid(load_valid), .load_data(load_data),
    .misaligned(misaligned), .access_err(access_err), .timeout_err(timeout_err),
    .mem_Read(mem_Read), .mem_Write(mem_Write), .mem_Address(mem_Address),
    .mem_Write_data(mem_Write_data), .mem_Func3(mem_Func3),
    .mem_Read_data(mem_Read_data), .mem_busywait(mem_busywait)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory: busy for m_lat edges after the first edge that sees the strobe.
  assign mem_busywait = (mem_Read | mem_Write) && (m_cnt <= m_lat);

  always @(posedge Clock or posedge Reset) begin
    if (Reset)                      m_cnt <= 0;
    else if (mem_Read | mem_Write)  m_cnt <= m_cnt + 1;
    else                            m_cnt <= 0;
  end

  always @(posedge Clock) begin
    if (m_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
    end else if (mem_Write && !mem_busywait) begin
      for (int i = 0; i < (1 << mem_Func3[1:0]); i++)
        mem[6'(int'(mem_Address[5:0]) + i)] <= mem_Write_data[8*i +: 8];
    end
  end

  // Word read, lane shift and extension done by the memory.
  always_comb begin
    m_word = {mem[{mem_Address[5:2], 2'b11}], mem[{mem_Address[5:2], 2'b10}],
              mem[{mem_Address[5:2], 2'b01}], mem[{mem_Address[5:2], 2'b00}]};
    m_sh   = m_word >> (8 * mem_Address[1:0]);
    case (mem_Func3)
      3'b000:  mem_Read_data = {{24{m_sh[7]}}, m_sh[7:0]};
      3'b001:  mem_Read_data = {{16{m_sh[15]}}, m_sh[15:0]};
      3'b100:  mem_Read_data = {24'h0, m_sh[7:0]};
      3'b101:  mem_Read_data = {16'h0, m_sh[15:0]};
      default: mem_Read_data = m_sh;
    endcase
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference value of a load, assembled byte by byte from the reference memory.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = 1 << f3[1:0];
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a[5:0]) + i]) << (8 * i));
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // One pipeline request, held while stalled, through DONE and one cycle beyond.
  task automatic run_req(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int lat);
    logic bad, mis, go, tmo, done;
    int   size, wcy, exp_cyc, scyc, rcyc, wrcyc, both, unstable;
    bad  = (ld && st) || (ld && !st && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) ||
           (st && !ld && f3 > 3'b010);
    size = 1 << f3[1:0];
    mis  = !bad && (ld || st) && ((int'(a[5:0]) % size) != 0);
    go   = (ld || st) && !bad && !mis;
    wcy  = lat + 1;
    tmo  = go && (wcy > TMO);
    if (tmo) wcy = TMO;
    exp_cyc = go ? wcy + 2 : 0;
    if (go && ld && !tmo) exp_ld = ref_load(f3, a);
    if (go && st && !tmo)
      for (int i = 0; i < size; i++) ref_mem[int'(a[5:0]) + i] = 8'(wd >> (8 * i));

    @(negedge Clock);
    m_lat = lat;
    req_valid = 1'b1; req_load = ld; req_store = st;
    req_func3 = f3; req_addr = a; req_wdata = wd;
    scyc = 0; rcyc = 0; wrcyc = 0; both = 0; unstable = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_Read && mem_Write) both++;
      if (mem_Read || mem_Write)
        if (mem_Address !== a || mem_Func3 !== f3 || (st && mem_Write_data !== wd)) unstable++;
      if (!stall) begin
        done = 1'b1;
        break;
      end
      scyc++;
      if (mem_Read)  rcyc++;
      if (mem_Write) wrcyc++;
      @(negedge Clock);
    end
    chk1({nm, "_bounded"}, done, 1'b1);
    chk32({nm, "_stall_cycles"}, scyc, exp_cyc);
    chk32({nm, "_both_strobes"}, both, 0);
    if (go) begin
      chk1({nm, "_load_valid"}, load_valid, ld && !tmo);
      chk1({nm, "_timeout_err"}, timeout_err, tmo);
      chk32({nm, "_load_data"}, load_data, exp_ld);
      chk32({nm, "_read_cycles"}, rcyc, ld ? scyc - 1 : 0);
      chk32({nm, "_write_cycles"}, wrcyc, st ? scyc - 1 : 0);
      chk32({nm, "_addr_stable"}, unstable, 0);
      chk1({nm, "_strobe_dropped"}, mem_Read | mem_Write, 1'b0);
    end
    @(negedge Clock);
    req_valid = 1'b0;
    #1;
    chk1({nm, "_post_stall"}, stall, 1'b0);
    chk1({nm, "_post_strobe"}, mem_Read | mem_Write, 1'b0);
    chk1({nm, "_access_err"}, access_err, bad);
    chk1({nm, "_misaligned"}, misaligned, mis);
    chk1({nm, "_post_load_valid"}, load_valid, 1'b0);
    chk32({nm, "_post_load_data"}, load_data, exp_ld);
  endtask

  initial begin
    int k;
    logic ld, st;
    n_cmp = 0; n_err = 0;
    Reset = 1'b1; m_load = 1'b1; m_lat = 0; exp_ld = 32'h0;
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_func3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      init_mem[i] = 8'($urandom);
      ref_mem[i]  = init_mem[i];
    end
    init_mem[16] = 8'hEF; init_mem[17] = 8'hBE; init_mem[18] = 8'hAD; init_mem[19] = 8'hDE;
    ref_mem[16]  = 8'hEF; ref_mem[17]  = 8'hBE; ref_mem[18]  = 8'hAD; ref_mem[19]  = 8'hDE;

    // Reset state.
    #2;
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_read", mem_Read, 1'b0);
    chk1("rst_write", mem_Write, 1'b0);
    chk32("rst_addr", mem_Address, 32'h0);
    chk32("rst_load_data", load_data, 32'h0);
    chk1("rst_flags", load_valid | misaligned | access_err | timeout_err, 1'b0);
    @(negedge Clock);
    @(negedge Clock);
    m_load = 1'b0;
    Reset  = 1'b0;

    // Basic word load.
    run_req("t1_lw", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0);
    chk32("t1_value", load_data, 32'hDEAD_BEEF);

    // Byte store into the top lane, then read the word back.
    run_req("t2_sb", 1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_00A5, 1);
    run_req("t2_lw", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 2);
    chk32("t2_top_byte", {24'h0, load_data[31:24]}, 32'hA5);

    // Halfword aligned, then misaligned.
    run_req("t3_lh_ok", 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 0);
    run_req("t3_lh_mis", 1'b1, 1'b0, 3'b001, 32'h11, 32'h0, 0);

    // Illegal combinations, including illegal+misaligned.
    run_req("t4_ldst", 1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 0);
    run_req("t4_f3_011", 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 0);
    run_req("t4_sbu", 1'b0, 1'b1, 3'b100, 32'h11, 32'h0, 0);

    // Memory stuck busy: abort after TMO WAIT cycles, load_data untouched.
    run_req("t5_tmo", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 20);
    run_req("t5_edge", 1'b1, 1'b0, 3'b010, 32'h14, 32'h0, TMO - 1);

    // Asynchronous reset in the middle of WAIT.
    @(negedge Clock);
    m_lat = 50;
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
    req_func3 = 3'b010; req_addr = 32'h14; req_wdata = 32'h0;
    @(negedge Clock);
    @(negedge Clock);
    #1;
    chk1("t6_wait_read", mem_Read, 1'b1);
    chk1("t6_wait_stall", stall, 1'b1);
    #2;
    Reset = 1'b1; req_valid = 1'b0;
    #1;
    chk1("t6_rst_read", mem_Read, 1'b0);
    chk1("t6_rst_stall", stall, 1'b0);
    chk32("t6_rst_load_data", load_data, 32'h0);
    exp_ld = 32'h0;
    @(negedge Clock);
    Reset = 1'b0;
    run_req("t6_after", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0);

    // Randomized requests.
    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 11));
      if (k == 0)      begin ld = 1'b1; st = 1'b1; end
      else if (k == 1) begin ld = 1'b0; st = 1'b0; end
      else             begin ld = (k % 2 == 0); st = !ld; end
      run_req("rnd", ld, st, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)),
              $urandom, int'($urandom_range(0, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
